// File: rtl/tone_gen_if.sv
// tone_gen_if -- note request / status bundle between a note sequencer and
// tone_gen.
//   HALF_PER [15:0]  half-period in CLK cycles, 0 = rest    (master -> slave)
//   DUR_MS   [15:0]  note duration in ms                     (master -> slave)
//   START            play request, taken when READY=1        (master -> slave)
//   READY            idle, able to accept START              (slave -> master)
//   DONE             one-cycle pulse at note completion      (slave -> master)
//   SPKR             square-wave speaker output              (slave -> master)
interface tone_gen_if;
  logic [15:0] HALF_PER;
  logic [15:0] DUR_MS;
  logic        START;
  logic        READY;
  logic        DONE;
  logic        SPKR;

  modport master (
    output HALF_PER, DUR_MS, START,
    input  READY, DONE, SPKR
  );

  modport slave (
    input  HALF_PER, DUR_MS, START,
    output READY, DONE, SPKR
  );
endinterface

// File: rtl/tone_gen.sv
// tone_gen -- square-wave tone generator, one note at a time.
// A note (half-period, duration in ms) is accepted on START while READY=1.
// SPKR toggles every HALF_PER cycles for DUR_MS*TICK_DIV cycles, then DONE
// pulses for one cycle. HALF_PER=0 plays a silent rest; DUR_MS=0 completes
// immediately with a DONE pulse on the following cycle.
//
// Parameters:
//   TICK_DIV  CLK cycles per millisecond (>= 1)
//   GAP_MS    silent gap after each note in ms (>= 1), TONE_GEN_GAP_EN only
//
// Ports:
//   CLK    system clock
//   RST_N  synchronous active-low reset (aborts a note without DONE)
//   bus    tone_gen_if.slave: HALF_PER, DUR_MS, START in; READY, DONE, SPKR out
//
// Build option:
//   TONE_GEN_GAP_EN  when defined, every note is followed by GAP_MS ms of
//                    silence before DONE/READY (detached playback); when
//                    undefined, PLAY returns straight to IDLE (legato).
module tone_gen #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned GAP_MS   = 10
) (
  input logic      CLK,
  input logic      RST_N,
  tone_gen_if.slave bus
);

  localparam int unsigned PC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(TICK_DIV - 1);

  if (TICK_DIV < 1 || GAP_MS < 1) begin : g_param_check
    $error("tone_gen: TICK_DIV and GAP_MS must both be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY
`ifdef TONE_GEN_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      hp_q, hp_d;
  logic [15:0]      hc_q, hc_d;
  logic [15:0]      ms_q, ms_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             spkr_q, spkr_d;
  logic             tick;

  assign tick = (pc_q == PC_LAST);

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    hc_d    = hc_q;
    ms_d    = ms_q;
    pc_d    = pc_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    spkr_d  = spkr_q;

    case (state_q)
      S_IDLE: begin
        spkr_d = 1'b0;
        if (bus.START && ready_q) begin
          hp_d = bus.HALF_PER;
          ms_d = bus.DUR_MS;
          hc_d = '0;
          pc_d = '0;
          if (bus.DUR_MS == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_PLAY;
            ready_d = 1'b0;
          end
        end
      end

      S_PLAY: begin
        if (hp_q != 16'd0) begin
          if (hc_q == hp_q - 16'd1) begin
            spkr_d = ~spkr_q;
            hc_d   = '0;
          end else begin
            hc_d = hc_q + 16'd1;
          end
        end

        if (tick) begin
          pc_d = '0;
          ms_d = ms_q - 16'd1;
          // Last millisecond ends the note; the forced SPKR=0 overrides any
          // toggle landing on the same edge.
          if (ms_q == 16'd1) begin
            spkr_d = 1'b0;
            hc_d   = '0;
`ifdef TONE_GEN_GAP_EN
            // The gap reuses the ms/prescaler counters for its own timing.
            state_d = S_GAP;
            ms_d    = 16'(GAP_MS);
`else
            state_d = S_IDLE;
            ready_d = 1'b1;
            done_d  = 1'b1;
`endif
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

`ifdef TONE_GEN_GAP_EN
      S_GAP: begin
        spkr_d = 1'b0;
        if (tick) begin
          pc_d = '0;
          ms_d = ms_q - 16'd1;
          if (ms_q == 16'd1) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        spkr_d  = 1'b0;
        hc_d    = '0;
        pc_d    = '0;
        ms_d    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      hp_q    <= '0;
      hc_q    <= '0;
      ms_q    <= '0;
      pc_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      spkr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      hc_q    <= hc_d;
      ms_q    <= ms_d;
      pc_q    <= pc_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      spkr_q  <= spkr_d;
    end
  end

  assign bus.READY = ready_q;
  assign bus.DONE  = done_q;
  assign bus.SPKR  = spkr_q;

endmodule
